// File: rtl/ysyx_24110015_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_pkg
// Shared definitions for the core's AXI4-Lite plumbing:
//   arb_state_t        - arbiter FSM states
//   AXI_RESP_OKAY      - xRESP encoding for a normal completion
//   AXI_RESP_SLVERR    - xRESP encoding for a slave error
//   LSU_FIRST_DEFAULT  - default tie-break (1: LSU wins simultaneous requests)
// ---------------------------------------------------------------------------
package ysyx_24110015_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WRESP = 3'd4
  } arb_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam bit LSU_FIRST_DEFAULT = 1'b1;

endpackage

// File: rtl/axi_lite_if.sv
// ---------------------------------------------------------------------------
// axi_lite_if
// AXI4-Lite channel bundle used between IFU/LSU, the arbiter and the xbar.
//   ADDR_W - address width of AR/AW
//   DATA_W - data width of R/W; wstrb is DATA_W/8 bits
// Modports:
//   master - drives AR/AW/W valids+payload and R/B readies
//   slave  - drives AR/AW/W readies and R/B valids+payload
// ---------------------------------------------------------------------------
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arsize;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awsize;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic       bvalid;
  logic       bready;
  logic [1:0] bresp;

  modport master (
    output arvalid, araddr, arsize, input  arready,
    input  rvalid, rdata, rresp,    output rready,
    output awvalid, awaddr, awsize, input  awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bresp,           output bready
  );

  modport slave (
    input  arvalid, araddr, arsize, output arready,
    output rvalid, rdata, rresp,    input  rready,
    input  awvalid, awaddr, awsize, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp,           input  bready
  );
endinterface

// File: rtl/ysyx_24110015_axi_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_axi_arbiter
// Two-master / one-slave AXI4-Lite arbiter. One transaction in flight; the
// grant is locked from request until the R or B handshake, so one master's
// AR/R or AW/W/B sequence is never interleaved with the other's.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset
//   m0    - IFU master port (slave modport)
//   m1    - LSU master port (slave modport)
//   s     - downstream port toward the xbar (master modport)
//   busy  - high whenever the FSM is not IDLE
//   grant - owning master (0 = m0, 1 = m1), meaningful while busy
// ---------------------------------------------------------------------------
module ysyx_24110015_axi_arbiter
  import ysyx_24110015_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter bit LSU_FIRST = LSU_FIRST_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  axi_lite_if.slave  m0,
  axi_lite_if.slave  m1,
  axi_lite_if.master s,
  output logic       busy,
  output logic       grant
);

  arb_state_t st_reg, st_next;
  logic own_reg, own_next;
  logic aw_done_reg, aw_done_next;
  logic w_done_reg, w_done_next;

  // Owner's request-side signals
  logic                sel_arvalid;
  logic [ADDR_W-1:0]   sel_araddr;
  logic [2:0]          sel_arsize;
  logic                sel_rready;
  logic                sel_awvalid;
  logic [ADDR_W-1:0]   sel_awaddr;
  logic [2:0]          sel_awsize;
  logic                sel_wvalid;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W/8-1:0] sel_wstrb;
  logic                sel_wlast;
  logic                sel_bready;

  // Slave-side responses qualified by state, before routing to the owner
  logic              rsp_arready;
  logic              rsp_rvalid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_rresp;
  logic              rsp_awready;
  logic              rsp_wready;
  logic              rsp_bvalid;
  logic [1:0]        rsp_bresp;

  logic req0, req1, win;
  logic aw_hs, w_hs;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_reg      <= IDLE;
      own_reg     <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      st_reg      <= st_next;
      own_reg     <= own_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
    end
  end

  // -------------------------------------------------------------------------
  // Owner mux on the request side
  // -------------------------------------------------------------------------
  always_comb begin
    if (own_reg) begin
      sel_arvalid = m1.arvalid;
      sel_araddr  = m1.araddr;
      sel_arsize  = m1.arsize;
      sel_rready  = m1.rready;
      sel_awvalid = m1.awvalid;
      sel_awaddr  = m1.awaddr;
      sel_awsize  = m1.awsize;
      sel_wvalid  = m1.wvalid;
      sel_wdata   = m1.wdata;
      sel_wstrb   = m1.wstrb;
      sel_wlast   = m1.wlast;
      sel_bready  = m1.bready;
    end else begin
      sel_arvalid = m0.arvalid;
      sel_araddr  = m0.araddr;
      sel_arsize  = m0.arsize;
      sel_rready  = m0.rready;
      sel_awvalid = m0.awvalid;
      sel_awaddr  = m0.awaddr;
      sel_awsize  = m0.awsize;
      sel_wvalid  = m0.wvalid;
      sel_wdata   = m0.wdata;
      sel_wstrb   = m0.wstrb;
      sel_wlast   = m0.wlast;
      sel_bready  = m0.bready;
    end
  end

  // -------------------------------------------------------------------------
  // Downstream drive: only the channel belonging to the current state is
  // opened; everything else is held at zero.
  // -------------------------------------------------------------------------
  always_comb begin
    s.arvalid = 1'b0;
    s.araddr  = '0;
    s.arsize  = '0;
    s.rready  = 1'b0;
    s.awvalid = 1'b0;
    s.awaddr  = '0;
    s.awsize  = '0;
    s.wvalid  = 1'b0;
    s.wdata   = '0;
    s.wstrb   = '0;
    s.wlast   = 1'b0;
    s.bready  = 1'b0;
    case (st_reg)
      RADDR: begin
        s.arvalid = sel_arvalid;
        s.araddr  = sel_araddr;
        s.arsize  = sel_arsize;
      end
      RDATA: s.rready = sel_rready;
      WADDR: begin
        // A channel that already handshook must not present a second beat.
        s.awvalid = sel_awvalid & ~aw_done_reg;
        s.awaddr  = sel_awaddr;
        s.awsize  = sel_awsize;
        s.wvalid  = sel_wvalid & ~w_done_reg;
        s.wdata   = sel_wdata;
        s.wstrb   = sel_wstrb;
        s.wlast   = sel_wlast;
      end
      WRESP: s.bready = sel_bready;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Slave responses qualified by state
  // -------------------------------------------------------------------------
  always_comb begin
    rsp_arready = (st_reg == RADDR) & s.arready;
    rsp_rvalid  = (st_reg == RDATA) & s.rvalid;
    rsp_rdata   = (st_reg == RDATA) ? s.rdata : '0;
    rsp_rresp   = (st_reg == RDATA) ? s.rresp : AXI_RESP_OKAY;
    rsp_awready = (st_reg == WADDR) & ~aw_done_reg & s.awready;
    rsp_wready  = (st_reg == WADDR) & ~w_done_reg & s.wready;
    rsp_bvalid  = (st_reg == WRESP) & s.bvalid;
    rsp_bresp   = (st_reg == WRESP) ? s.bresp : AXI_RESP_OKAY;
  end

  // -------------------------------------------------------------------------
  // Route responses to the owner; the other master sees all zeros.
  // -------------------------------------------------------------------------
  always_comb begin
    m0.arready = ~own_reg & rsp_arready;
    m0.rvalid  = ~own_reg & rsp_rvalid;
    m0.rdata   = own_reg ? '0 : rsp_rdata;
    m0.rresp   = own_reg ? AXI_RESP_OKAY : rsp_rresp;
    m0.awready = ~own_reg & rsp_awready;
    m0.wready  = ~own_reg & rsp_wready;
    m0.bvalid  = ~own_reg & rsp_bvalid;
    m0.bresp   = own_reg ? AXI_RESP_OKAY : rsp_bresp;

    m1.arready = own_reg & rsp_arready;
    m1.rvalid  = own_reg & rsp_rvalid;
    m1.rdata   = own_reg ? rsp_rdata : '0;
    m1.rresp   = own_reg ? rsp_rresp : AXI_RESP_OKAY;
    m1.awready = own_reg & rsp_awready;
    m1.wready  = own_reg & rsp_wready;
    m1.bvalid  = own_reg & rsp_bvalid;
    m1.bresp   = own_reg ? rsp_bresp : AXI_RESP_OKAY;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    st_next      = st_reg;
    own_next     = own_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;

    req0 = m0.arvalid | m0.awvalid;
    req1 = m1.arvalid | m1.awvalid;
    win  = (req0 & req1) ? LSU_FIRST : req1;

    aw_hs = (st_reg == WADDR) & sel_awvalid & ~aw_done_reg & s.awready;
    w_hs  = (st_reg == WADDR) & sel_wvalid & ~w_done_reg & s.wready;

    case (st_reg)
      IDLE: begin
        if (req0 | req1) begin
          own_next = win;
          // Reads take priority over writes within the winning master.
          if (win ? m1.arvalid : m0.arvalid) st_next = RADDR;
          else                               st_next = WADDR;
        end
      end
      RADDR: if (sel_arvalid & s.arready) st_next = RDATA;
      RDATA: if (s.rvalid & sel_rready)   st_next = IDLE;
      WADDR: begin
        if ((aw_done_reg | aw_hs) & (w_done_reg | w_hs)) begin
          st_next      = WRESP;
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
        end else begin
          aw_done_next = aw_done_reg | aw_hs;
          w_done_next  = w_done_reg | w_hs;
        end
      end
      WRESP: if (s.bvalid & sel_bready) st_next = IDLE;
      default: st_next = IDLE;
    endcase
  end

  assign busy  = (st_reg != IDLE);
  assign grant = own_reg;

endmodule

// File: tb/tb_ysyx_24110015_axi_arbiter.sv
module tb_ysyx_24110015_axi_arbiter;
  import ysyx_24110015_pkg::*;

  localparam int K_AR = 0;
  localparam int K_AW = 1;
  localparam int K_W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  axi_lite_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  axi_lite_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  axi_lite_if #(.ADDR_W(32), .DATA_W(32)) s_if ();
  logic busy, grant;

  ysyx_24110015_axi_arbiter #(.ADDR_W(32), .DATA_W(32), .LSU_FIRST(1'b1)) dut (
    .clk  (clk),
    .rst  (rst),
    .m0   (m0_if),
    .m1   (m1_if),
    .s    (s_if),
    .busy (busy),
    .grant(grant)
  );

  // Master-side stimulus, indexed by master number
  logic        m_arvalid[2], m_rready[2], m_awvalid[2], m_wvalid[2], m_wlast[2], m_bready[2];
  logic [31:0] m_araddr[2], m_awaddr[2], m_wdata[2];
  logic [2:0]  m_arsize[2], m_awsize[2];
  logic [3:0]  m_wstrb[2];
  logic        m_arready[2], m_rvalid[2], m_awready[2], m_wready[2], m_bvalid[2];
  logic [31:0] m_rdata[2];
  logic [1:0]  m_rresp[2], m_bresp[2];

  assign m0_if.arvalid = m_arvalid[0]; assign m0_if.araddr = m_araddr[0]; assign m0_if.arsize = m_arsize[0];
  assign m0_if.rready  = m_rready[0];  assign m0_if.awvalid = m_awvalid[0]; assign m0_if.awaddr = m_awaddr[0];
  assign m0_if.awsize  = m_awsize[0];  assign m0_if.wvalid = m_wvalid[0]; assign m0_if.wdata = m_wdata[0];
  assign m0_if.wstrb   = m_wstrb[0];   assign m0_if.wlast = m_wlast[0];   assign m0_if.bready = m_bready[0];
  assign m_arready[0] = m0_if.arready; assign m_rvalid[0] = m0_if.rvalid; assign m_rdata[0] = m0_if.rdata;
  assign m_rresp[0] = m0_if.rresp;     assign m_awready[0] = m0_if.awready; assign m_wready[0] = m0_if.wready;
  assign m_bvalid[0] = m0_if.bvalid;   assign m_bresp[0] = m0_if.bresp;

  assign m1_if.arvalid = m_arvalid[1]; assign m1_if.araddr = m_araddr[1]; assign m1_if.arsize = m_arsize[1];
  assign m1_if.rready  = m_rready[1];  assign m1_if.awvalid = m_awvalid[1]; assign m1_if.awaddr = m_awaddr[1];
  assign m1_if.awsize  = m_awsize[1];  assign m1_if.wvalid = m_wvalid[1]; assign m1_if.wdata = m_wdata[1];
  assign m1_if.wstrb   = m_wstrb[1];   assign m1_if.wlast = m_wlast[1];   assign m1_if.bready = m_bready[1];
  assign m_arready[1] = m1_if.arready; assign m_rvalid[1] = m1_if.rvalid; assign m_rdata[1] = m1_if.rdata;
  assign m_rresp[1] = m1_if.rresp;     assign m_awready[1] = m1_if.awready; assign m_wready[1] = m1_if.wready;
  assign m_bvalid[1] = m1_if.bvalid;   assign m_bresp[1] = m1_if.bresp;

  // ---------------------------------------------------------------------
  // Slave model: always-ready AR/AW/W, R after rd_delay extra cycles,
  // B one cycle after both AW and W have been accepted.
  // ---------------------------------------------------------------------
  typedef struct {
    int          kind;
    logic        mst;
    logic [31:0] val;
    logic [3:0]  strb;
    int unsigned at;
  } ev_t;
  ev_t obs_q[$];
  ev_t exp_q[$];

  int         rd_delay = 0;
  logic [1:0] b_resp_knob = AXI_RESP_OKAY;

  logic        s_rvalid, s_bvalid, rd_pend, aw_seen, w_seen;
  logic [31:0] s_rdata, rd_addr;
  logic [1:0]  s_rresp, s_bresp;
  int          rd_cnt;
  logic        sl_aw_hs, sl_w_hs;

  assign s_if.arready = 1'b1;
  assign s_if.awready = 1'b1;
  assign s_if.wready  = 1'b1;
  assign s_if.rvalid  = s_rvalid;
  assign s_if.rdata   = s_rdata;
  assign s_if.rresp   = s_rresp;
  assign s_if.bvalid  = s_bvalid;
  assign s_if.bresp   = s_bresp;
  assign sl_aw_hs = s_if.awvalid & s_if.awready;
  assign sl_w_hs  = s_if.wvalid & s_if.wready;

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return (a == 32'h8000_0004) ? 32'hDEAD_BEEF : ~a;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_rvalid <= 1'b0; s_rdata <= '0; s_rresp <= '0;
      s_bvalid <= 1'b0; s_bresp <= '0;
      rd_pend <= 1'b0; rd_cnt <= 0; rd_addr <= '0;
      aw_seen <= 1'b0; w_seen <= 1'b0;
    end else begin
      if (s_if.arvalid && s_if.arready) begin
        obs_q.push_back('{K_AR, grant, s_if.araddr, 4'h0, cyc});
        rd_pend <= 1'b1;
        rd_cnt  <= rd_delay;
        rd_addr <= s_if.araddr;
      end
      if (rd_pend && !s_rvalid) begin
        if (rd_cnt == 0) begin
          s_rvalid <= 1'b1;
          s_rdata  <= slave_rd(rd_addr);
          s_rresp  <= AXI_RESP_OKAY;
          rd_pend  <= 1'b0;
        end else begin
          rd_cnt <= rd_cnt - 1;
        end
      end
      if (s_rvalid && s_if.rready) s_rvalid <= 1'b0;
      if (sl_aw_hs) obs_q.push_back('{K_AW, grant, s_if.awaddr, 4'h0, cyc});
      if (sl_w_hs)  obs_q.push_back('{K_W, grant, s_if.wdata, s_if.wstrb, cyc});
      if ((aw_seen || sl_aw_hs) && (w_seen || sl_w_hs)) begin
        s_bvalid <= 1'b1;
        s_bresp  <= b_resp_knob;
        aw_seen  <= 1'b0;
        w_seen   <= 1'b0;
      end else begin
        if (sl_aw_hs) aw_seen <= 1'b1;
        if (sl_w_hs)  w_seen  <= 1'b1;
      end
      if (s_bvalid && s_if.bready) s_bvalid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Master transaction tasks
  // ---------------------------------------------------------------------
  task automatic do_read(input int idx, input logic [31:0] addr,
                         output logic [31:0] data, output logic [1:0] resp,
                         output int unsigned ar_cyc, output int unsigned r_cyc, output bit ok);
    int n;
    ok = 1'b1; data = '0; resp = '0; ar_cyc = 0; r_cyc = 0;
    @(negedge clk);
    m_arvalid[idx] = 1'b1; m_araddr[idx] = addr; m_arsize[idx] = 3'd2; m_rready[idx] = 1'b1;
    #1;
    n = 0;
    while (!m_arready[idx] && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin ok = 1'b0; m_arvalid[idx] = 1'b0; m_rready[idx] = 1'b0; return; end
    ar_cyc = cyc;
    @(negedge clk);
    m_arvalid[idx] = 1'b0;
    n = 0;
    while (!m_rvalid[idx] && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin ok = 1'b0; m_rready[idx] = 1'b0; return; end
    data = m_rdata[idx]; resp = m_rresp[idx]; r_cyc = cyc;
    @(negedge clk);
    m_rready[idx] = 1'b0;
  endtask

  task automatic do_write(input int idx, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int wdelay,
                          output logic [1:0] resp, output bit ok);
    int n;
    ok = 1'b1; resp = '0;
    @(negedge clk);
    m_bready[idx] = 1'b1;
    fork
      begin : aw_thread
        int na;
        m_awvalid[idx] = 1'b1; m_awaddr[idx] = addr; m_awsize[idx] = 3'd2;
        #1;
        na = 0;
        while (!m_awready[idx] && na < 200) begin @(negedge clk); na++; end
        if (na >= 200) ok = 1'b0;
        @(negedge clk);
        m_awvalid[idx] = 1'b0;
      end
      begin : w_thread
        int nw;
        repeat (wdelay) @(negedge clk);
        m_wvalid[idx] = 1'b1; m_wdata[idx] = data; m_wstrb[idx] = strb; m_wlast[idx] = 1'b1;
        #1;
        nw = 0;
        while (!m_wready[idx] && nw < 200) begin @(negedge clk); nw++; end
        if (nw >= 200) ok = 1'b0;
        @(negedge clk);
        m_wvalid[idx] = 1'b0; m_wlast[idx] = 1'b0;
      end
    join
    n = 0;
    while (!m_bvalid[idx] && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) ok = 1'b0;
    resp = m_bresp[idx];
    @(negedge clk);
    m_bready[idx] = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset;
    rst = 1'b0;
    m_arvalid[0] = 1'b1; m_araddr[0] = 32'h3000_0000; m_rready[0] = 1'b1;
    m_arvalid[1] = 1'b1; m_araddr[1] = 32'h8000_0004; m_rready[1] = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (s_if.arvalid !== 1'b0) begin failures++; $display("FAIL rst_s_arvalid got=%b want=0", s_if.arvalid); end
    checks++; if (s_if.awvalid !== 1'b0 || s_if.wvalid !== 1'b0) begin failures++; $display("FAIL rst_s_aw_w_valid got=%b%b want=00", s_if.awvalid, s_if.wvalid); end
    checks++; if (s_if.rready !== 1'b0 || s_if.bready !== 1'b0) begin failures++; $display("FAIL rst_s_readies got=%b%b want=00", s_if.rready, s_if.bready); end
    checks++; if (m_arready[0] !== 1'b0 || m_arready[1] !== 1'b0) begin failures++; $display("FAIL rst_m_arready got=%b%b want=00", m_arready[1], m_arready[0]); end
    checks++; if (busy !== 1'b0 || grant !== 1'b0) begin failures++; $display("FAIL rst_busy_grant got=%b%b want=00", busy, grant); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || grant !== 1'b1) begin failures++; $display("FAIL rel_busy_grant got=%b%b want=11", busy, grant); end
    checks++; if (s_if.arvalid !== 1'b1 || s_if.araddr !== 32'h8000_0004) begin failures++; $display("FAIL rel_s_ar got=%b/%h want=1/80000004", s_if.arvalid, s_if.araddr); end
    checks++; if (m_arready[0] !== 1'b0) begin failures++; $display("FAIL rel_m0_arready got=%b want=0", m_arready[0]); end
    // Abort this transaction with a second reset before any handshake.
    rst = 1'b0;
    m_arvalid[0] = 1'b0; m_arvalid[1] = 1'b0; m_rready[0] = 1'b0; m_rready[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_simultaneous_ar;
    logic [31:0] d0, d1; logic [1:0] r0, r1;
    int unsigned a0, a1, rc0, rc1; bit ok0, ok1; ev_t e, o;
    rd_delay = 0;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back('{K_AR, 1'b1, 32'h8000_0004, 4'h0, 0});
    exp_q.push_back('{K_AR, 1'b0, 32'h3000_0000, 4'h0, 0});
    fork
      do_read(0, 32'h3000_0000, d0, r0, a0, rc0, ok0);
      do_read(1, 32'h8000_0004, d1, r1, a1, rc1, ok1);
    join
    checks++; if (!ok0 || !ok1) begin failures++; $display("FAIL simar_timeout ok0=%0d ok1=%0d want=1/1", ok0, ok1); end
    checks++; if (d1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL simar_m1_rdata got=%h want=deadbeef", d1); end
    checks++; if (d0 !== slave_rd(32'h3000_0000)) begin failures++; $display("FAIL simar_m0_rdata got=%h want=%h", d0, slave_rd(32'h3000_0000)); end
    checks++; if (r0 !== AXI_RESP_OKAY || r1 !== AXI_RESP_OKAY) begin failures++; $display("FAIL simar_rresp got=%b/%b want=00/00", r0, r1); end
    checks++; if (a0 !== rc1 + 2) begin failures++; $display("FAIL simar_turnaround m0_ar_cyc=%0d want=%0d", a0, rc1 + 2); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL simar_sb missing kind=%0d addr=%h", e.kind, e.val); end
      else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.mst !== e.mst || o.val !== e.val) begin
          failures++; $display("FAIL simar_sb got=%0d/%b/%h want=%0d/%b/%h", o.kind, o.mst, o.val, e.kind, e.mst, e.val);
        end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL simar_sb_extra got=%0d want=0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_lsu_delayed_write;
    logic [1:0] br; bit ok; int unsigned aw_at, w_at, b_first; ev_t e, o;
    b_resp_knob = AXI_RESP_OKAY;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back('{K_AW, 1'b1, 32'h0F00_0010, 4'h0, 0});
    exp_q.push_back('{K_W,  1'b1, 32'h1234_5678, 4'b1100, 0});
    b_first = 0;
    fork
      do_write(1, 32'h0F00_0010, 32'h1234_5678, 4'b1100, 2, br, ok);
      begin : mon_b
        for (int i = 0; i < 100 && b_first == 0; i++) begin
          @(negedge clk);
          if (s_if.bready) b_first = cyc;
        end
      end
    join
    aw_at = (obs_q.size() > 0) ? obs_q[0].at : 0;
    w_at  = (obs_q.size() > 1) ? obs_q[1].at : 0;
    checks++; if (!ok) begin failures++; $display("FAIL dw_timeout ok=%0d want=1", ok); end
    checks++; if (br !== AXI_RESP_OKAY) begin failures++; $display("FAIL dw_bresp got=%b want=00", br); end
    checks++; if (w_at !== aw_at + 1) begin failures++; $display("FAIL dw_w_after_aw w_at=%0d want=%0d", w_at, aw_at + 1); end
    checks++; if (b_first !== w_at + 1) begin failures++; $display("FAIL dw_wresp_after_w bready_cyc=%0d want=%0d", b_first, w_at + 1); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL dw_sb missing kind=%0d val=%h", e.kind, e.val); end
      else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.mst !== e.mst || o.val !== e.val || o.strb !== e.strb) begin
          failures++; $display("FAIL dw_sb got=%0d/%b/%h/%b want=%0d/%b/%h/%b", o.kind, o.mst, o.val, o.strb, e.kind, e.mst, e.val, e.strb);
        end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL dw_sb_extra got=%0d want=0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_same_cycle_write;
    logic [1:0] br; bit ok; int unsigned aw_at, w_at, b_first; ev_t e, o;
    b_resp_knob = AXI_RESP_SLVERR;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back('{K_AW, 1'b0, 32'h0000_1000, 4'h0, 0});
    exp_q.push_back('{K_W,  1'b0, 32'hCAFE_F00D, 4'hF, 0});
    b_first = 0;
    fork
      do_write(0, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 0, br, ok);
      begin : mon_b2
        for (int i = 0; i < 100 && b_first == 0; i++) begin
          @(negedge clk);
          if (s_if.bready) b_first = cyc;
        end
      end
    join
    aw_at = (obs_q.size() > 0) ? obs_q[0].at : 0;
    w_at  = (obs_q.size() > 1) ? obs_q[1].at : 1;
    checks++; if (!ok) begin failures++; $display("FAIL sc_timeout ok=%0d want=1", ok); end
    checks++; if (br !== AXI_RESP_SLVERR) begin failures++; $display("FAIL sc_bresp got=%b want=10", br); end
    checks++; if (w_at !== aw_at) begin failures++; $display("FAIL sc_same_cycle w_at=%0d want=%0d", w_at, aw_at); end
    checks++; if (b_first !== aw_at + 1) begin failures++; $display("FAIL sc_wresp_cyc bready_cyc=%0d want=%0d", b_first, aw_at + 1); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL sc_sb missing kind=%0d val=%h", e.kind, e.val); end
      else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.mst !== e.mst || o.val !== e.val || o.strb !== e.strb) begin
          failures++; $display("FAIL sc_sb got=%0d/%b/%h/%b want=%0d/%b/%h/%b", o.kind, o.mst, o.val, o.strb, e.kind, e.mst, e.val, e.strb);
        end
      end
    end
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL sc_sb_dup got=%0d want=0", obs_q.size()); obs_q.delete(); end
    b_resp_knob = AXI_RESP_OKAY;
  endtask

  task automatic test_back_pressure;
    logic [31:0] d0, d1; logic [1:0] r0, r1;
    int unsigned a0, a1, rc0, rc1; bit ok0, ok1;
    int busy_low, early1;
    rd_delay = 5;
    obs_q.delete(); exp_q.delete();
    busy_low = 0; early1 = 0;
    fork
      do_read(0, 32'h3000_0100, d0, r0, a0, rc0, ok0);
      begin : late_m1
        @(negedge clk); @(negedge clk);
        do_read(1, 32'h8000_0004, d1, r1, a1, rc1, ok1);
      end
      begin : mon_busy
        @(negedge clk);
        for (int i = 0; i < 60; i++) begin
          @(negedge clk);
          if (m_rvalid[0] && m_rready[0]) break;
          if (!busy) busy_low++;
          if (m_arready[1]) early1++;
        end
      end
    join
    checks++; if (!ok0 || !ok1) begin failures++; $display("FAIL bp_timeout ok0=%0d ok1=%0d want=1/1", ok0, ok1); end
    checks++; if (rc0 !== a0 + 7) begin failures++; $display("FAIL bp_rdata_delay r_cyc=%0d want=%0d", rc0, a0 + 7); end
    checks++; if (busy_low != 0) begin failures++; $display("FAIL bp_busy low_cycles=%0d want=0", busy_low); end
    checks++; if (early1 != 0) begin failures++; $display("FAIL bp_m1_early_grant cycles=%0d want=0", early1); end
    checks++; if (a1 !== rc0 + 2) begin failures++; $display("FAIL bp_m1_grant ar_cyc=%0d want=%0d", a1, rc0 + 2); end
    checks++; if (d0 !== slave_rd(32'h3000_0100) || d1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bp_rdata got=%h/%h want=%h/deadbeef", d0, d1, slave_rd(32'h3000_0100)); end
    rd_delay = 0;
    obs_q.delete();
  endtask

  task automatic test_reset_in_rdata;
    logic [31:0] d0; logic [1:0] r0; int unsigned a0, rc0; bit ok0; ev_t e, o;
    rd_delay = 20;
    obs_q.delete(); exp_q.delete();
    @(negedge clk);
    m_arvalid[0] = 1'b1; m_araddr[0] = 32'h3000_0200; m_arsize[0] = 3'd2; m_rready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_arvalid[0] = 1'b0;
    checks++; if (busy !== 1'b1 || s_if.rready !== 1'b1) begin failures++; $display("FAIL rr_in_rdata busy/rready got=%b%b want=11", busy, s_if.rready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || grant !== 1'b0) begin failures++; $display("FAIL rr_idle busy/grant got=%b%b want=00", busy, grant); end
    checks++; if (s_if.rready !== 1'b0 || m_rvalid[0] !== 1'b0) begin failures++; $display("FAIL rr_rready/rvalid got=%b%b want=00", s_if.rready, m_rvalid[0]); end
    m_rready[0] = 1'b0;
    rst = 1'b1;
    rd_delay = 1;
    obs_q.delete(); exp_q.delete();
    exp_q.push_back('{K_AR, 1'b0, 32'h3000_0300, 4'h0, 0});
    do_read(0, 32'h3000_0300, d0, r0, a0, rc0, ok0);
    checks++; if (!ok0 || d0 !== slave_rd(32'h3000_0300)) begin failures++; $display("FAIL rr_fresh_read ok=%0d got=%h want=%h", ok0, d0, slave_rd(32'h3000_0300)); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL rr_sb missing addr=%h", e.val); end
      else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.mst !== e.mst || o.val !== e.val) begin
          failures++; $display("FAIL rr_sb got=%0d/%b/%h want=%0d/%b/%h", o.kind, o.mst, o.val, e.kind, e.mst, e.val);
        end
      end
    end
    rd_delay = 0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_arvalid[i] = 1'b0; m_araddr[i] = '0; m_arsize[i] = '0; m_rready[i] = 1'b0;
      m_awvalid[i] = 1'b0; m_awaddr[i] = '0; m_awsize[i] = '0;
      m_wvalid[i] = 1'b0; m_wdata[i] = '0; m_wstrb[i] = '0; m_wlast[i] = 1'b0; m_bready[i] = 1'b0;
    end
    #2 rst = 1'b0;
    test_reset();
    test_simultaneous_ar();
    test_lsu_delayed_write();
    test_same_cycle_write();
    test_back_pressure();
    test_reset_in_rdata();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
